sseg_scan_ctrl: RTL and testbench

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_scan_ctrl.sv | 88 ++++++++
 tb/tb_sseg_scan_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sseg_scan_ctrl                                                |
// | Purpose  : 8-digit multiplexed seven-segment scanner with slot blanking  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sseg_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] en_mask,
  output logic [7:0] an,
  output logic [7:0] sseg,
  output logic [2:0] digit_idx,
  output logic       frame_tick
);

  localparam int                  c_CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK    = c_CNT_W'(BLANK);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_wrap;
  logic [7:0]         r_pat [8];
  logic [7:0]         w_an_nxt;
  logic [7:0]         w_sseg_nxt;
  logic [7:0]         w_one;

  // State tracks the counter value being loaded, so r_state always matches r_cnt.
  always_comb begin
    w_one       = 8'h01;
    w_wrap      = (r_cnt == c_CNT_LAST);
    w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
    w_state_nxt = (w_cnt_nxt < c_BLANK) ? S_BLANK : S_SHOW;
    w_an_nxt    = 8'hFF;
    w_sseg_nxt  = 8'hFF;
    if (r_state == S_SHOW && en_mask[digit_idx]) begin
      w_an_nxt   = ~(w_one << digit_idx);
      w_sseg_nxt = r_pat[digit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_BLANK;
      r_cnt      <= '0;
      digit_idx  <= 3'd0;
      an         <= 8'hFF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      an         <= w_an_nxt;
      sseg       <= w_sseg_nxt;
      frame_tick <= w_wrap && (digit_idx == 3'd7);
      if (w_wrap) begin
        digit_idx <= digit_idx + 3'd1;
      end
    end
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_pat[i] <= 8'hFF;
      end
    end else if (wr_en) begin
      r_pat[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sseg_scan_ctrl                                             |
// | Purpose  : Directed + randomised self-checking bench for sseg_scan_ctrl  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_sseg_scan_ctrl;

  localparam int c_DIV   = 10;
  localparam int c_BLANK = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] en_mask;
  logic [7:0] an;
  logic [7:0] sseg;
  logic [2:0] digit_idx;
  logic       frame_tick;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         t      = 0;
  logic [7:0] pat_m [8];

  sseg_scan_ctrl #(.DIV(c_DIV), .BLANK(c_BLANK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .en_mask    (en_mask),
    .an         (an),
    .sseg       (sseg),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @t=%0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  // One clock edge; expected outputs follow from edges since release (t),
  // the pre-edge shadow patterns and the mask sampled at that edge.
  task automatic step_chk();
    logic       rst_e = !reset_n;
    logic       we    = wr_en;
    logic [2:0] wa    = wr_addr;
    logic [7:0] wd    = wr_data;
    logic [7:0] msk   = en_mask;
    logic [7:0] one   = 8'h01;
    logic [7:0] e_an;
    logic [7:0] e_ss;
    int c;
    int d;
    @(posedge clk);
    #1;
    if (rst_e) begin
      t = 0;
      for (int i = 0; i < 8; i++) pat_m[i] = 8'hFF;
      check("rst_an",   32'(an),         32'hFF);
      check("rst_sseg", 32'(sseg),       32'hFF);
      check("rst_idx",  32'(digit_idx),  32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
    end else begin
      t++;
      c    = (t - 1) % c_DIV;
      d    = ((t - 1) / c_DIV) % 8;
      e_an = 8'hFF;
      e_ss = 8'hFF;
      if (c >= c_BLANK && msk[d]) begin
        e_an = ~(one << d);
        e_ss = pat_m[d];
      end
      check("an",     32'(an),                  32'(e_an));
      check("sseg",   32'(sseg),                32'(e_ss));
      check("idx",    32'(digit_idx),           32'((t / c_DIV) % 8));
      check("tick",   32'(frame_tick),          32'((t % (8 * c_DIV)) == 0));
      check("onehot", 32'($countones(~an) <= 1), 32'd1);
      if (we) pat_m[wa] = wd;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 8'h00;
    en_mask = 8'hFF;

    repeat (3) step_chk();

    // Frame 0: digit 0 shows the reset pattern before patterns are loaded.
    reset_n = 1'b1;
    while (t < 80) begin
      wr_en   = (t + 1 >= 4) && (t + 1 <= 11);
      wr_addr = 3'(t + 1 - 4);
      wr_data = 8'(8'h40 + t + 1 - 4);
      step_chk();
    end
    wr_en = 1'b0;

    while (t < 160) step_chk();

    en_mask = 8'b1111_1110;
    while (t < 240) step_chk();
    en_mask = 8'hFF;

    // Live write to pat[3] during digit 3 SHOW.
    while (t < 320) begin
      wr_en   = (t + 1 == 275);
      wr_addr = 3'd3;
      wr_data = 8'h00;
      step_chk();
    end
    wr_en = 1'b0;

    // Reset with a coincident write during digit 5 SHOW.
    while (t < 374) step_chk();
    reset_n = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 3'd5;
    wr_data = 8'h99;
    step_chk();
    reset_n = 1'b1;
    wr_en   = 1'b0;
    while (t < 80) step_chk();

    repeat (100 * 8 * c_DIV) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      en_mask = 8'($urandom);
      step_chk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
